// File: rtl/sub64_4stage_if.sv
// rtl/sub64_4stage_if.sv - stream bundle for the pipelined 64-bit subtractor
// Optional macro: SUB_STICKY_ERR_EN adds err_sticky to the bundle.
interface sub64_4stage_if;
  logic        en;
  logic        in_valid;
  logic [64:0] sum;
  logic [63:0] y;
  logic        out_valid;
  logic [63:0] x;
  logic        borrow;
  logic        hi;
`ifdef SUB_STICKY_ERR_EN
  logic        err_sticky;

  modport master (
    output en, in_valid, sum, y,
    input  out_valid, x, borrow, hi, err_sticky
  );
  modport slave (
    input  en, in_valid, sum, y,
    output out_valid, x, borrow, hi, err_sticky
  );
`else
  modport master (
    output en, in_valid, sum, y,
    input  out_valid, x, borrow, hi
  );
  modport slave (
    input  en, in_valid, sum, y,
    output out_valid, x, borrow, hi
  );
`endif
endinterface

// File: rtl/sub64_4stage.sv
// rtl/sub64_4stage.sv - 4-stage pipelined x = sum - y with registered borrow chain
// Optional macro: SUB_STICKY_ERR_EN enables the sticky borrow flag err_sticky.
module sub64_4stage #(
  parameter int SUB_WIDTH  = 16,
  parameter int DATA_WIDTH = 64
) (
  input  logic            clk,
  input  logic            rst,
  sub64_4stage_if.slave   bus
);
  localparam int W = SUB_WIDTH;

  if (SUB_WIDTH != 16 || DATA_WIDTH != 4 * SUB_WIDTH) begin : g_bad_cfg
    $error("sub64_4stage: SUB_WIDTH must be 16 and DATA_WIDTH must be 4*SUB_WIDTH");
  end

  // {borrow_out, difference} of one chunk
  function automatic logic [W:0] sub_chunk(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic         bin);
    return {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
  endfunction

  // Input skew: upper chunks (and sum bit 64) wait for the borrow to reach them
  logic [3*W:0]   sk1_sum;
  logic [3*W-1:0] sk1_y;
  logic [2*W:0]   sk2_sum;
  logic [2*W-1:0] sk2_y;
  logic [W:0]     sk3_sum;
  logic [W-1:0]   sk3_y;

  logic [W-1:0]   d0_r, d1_r, d2_r;
  logic           b0_r, b1_r, b2_r;

  // Output deskew: lower chunks wait for the upper ones
  logic [W-1:0]   dsk0_1, dsk0_2, dsk1_1;

  logic [2:0]     v_r;
  logic           out_valid_r;
  logic [4*W-1:0] x_r;
  logic           borrow_r;
  logic           hi_r;

  logic [W:0]     st0, st1, st2, st3;

  always_comb begin
    st0 = sub_chunk(bus.sum[W-1:0], bus.y[W-1:0], 1'b0);
    st1 = sub_chunk(sk1_sum[W-1:0], sk1_y[W-1:0], b0_r);
    st2 = sub_chunk(sk2_sum[W-1:0], sk2_y[W-1:0], b1_r);
    st3 = sub_chunk(sk3_sum[W-1:0], sk3_y, b2_r);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sk1_sum     <= '0;
      sk1_y       <= '0;
      sk2_sum     <= '0;
      sk2_y       <= '0;
      sk3_sum     <= '0;
      sk3_y       <= '0;
      d0_r        <= '0;
      d1_r        <= '0;
      d2_r        <= '0;
      b0_r        <= 1'b0;
      b1_r        <= 1'b0;
      b2_r        <= 1'b0;
      dsk0_1      <= '0;
      dsk0_2      <= '0;
      dsk1_1      <= '0;
      v_r         <= '0;
      out_valid_r <= 1'b0;
      x_r         <= '0;
      borrow_r    <= 1'b0;
      hi_r        <= 1'b0;
    end else if (bus.en) begin
      // stage 0
      d0_r    <= st0[W-1:0];
      b0_r    <= st0[W];
      sk1_sum <= bus.sum[4*W:W];
      sk1_y   <= bus.y[4*W-1:W];
      // stage 1
      d1_r    <= st1[W-1:0];
      b1_r    <= st1[W];
      dsk0_1  <= d0_r;
      sk2_sum <= sk1_sum[3*W:W];
      sk2_y   <= sk1_y[3*W-1:W];
      // stage 2
      d2_r    <= st2[W-1:0];
      b2_r    <= st2[W];
      dsk0_2  <= dsk0_1;
      dsk1_1  <= d1_r;
      sk3_sum <= sk2_sum[2*W:W];
      sk3_y   <= sk2_y[2*W-1:W];
      // stage 3 resolves bit 64 against the final borrow
      x_r      <= {st3[W-1:0], d2_r, dsk1_1, dsk0_2};
      borrow_r <= ~sk3_sum[W] & st3[W];
      hi_r     <= sk3_sum[W] & ~st3[W];
      v_r         <= {v_r[1:0], bus.in_valid};
      out_valid_r <= v_r[2];
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.x         = x_r;
  assign bus.borrow    = borrow_r;
  assign bus.hi        = hi_r;

`ifdef SUB_STICKY_ERR_EN
  logic err_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (out_valid_r && borrow_r) begin
      err_r <= 1'b1;
    end
  end

  assign bus.err_sticky = err_r;
`endif
endmodule
